// File: rtl/mbs_bus_pkg.sv
// Shared constants and helpers for the system memory bus arbiter and its
// priority picker.
package mbs_bus_pkg;

    localparam int NUM_REQ  = 3;
    localparam int REQ_DATA = 0;
    localparam int REQ_INST = 1;
    localparam int REQ_DMA  = 2;

    localparam int TIMEOUT_DEF      = 255;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Bits needed to count from 0 up to and including max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mbs_bus_arbiter_if.sv
// Requester and memory-side signals of the bus arbiter. The slave modport is
// the arbiter's view; the master modport is the view of the surrounding system.
interface mbs_bus_arbiter_if
    import mbs_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                            stop;
    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ-1:0]              we;
    logic [NUM_REQ*ADDR_WIDTH-1:0]   addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]   wdata;
    logic [NUM_REQ-1:0]              gnt;
    logic [NUM_REQ-1:0]              done;
    logic [DATA_WIDTH-1:0]           rdata;
    logic                            err;
    logic                            mem_req;
    logic                            mem_we;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic [DATA_WIDTH-1:0]           mem_wdata;
    logic [DATA_WIDTH-1:0]           mem_rdata;
    logic                            mem_ready;

    modport slave (
        input  stop, req, we, addr, wdata, mem_rdata, mem_ready,
        output gnt, done, rdata, err, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output stop, req, we, addr, wdata, mem_rdata, mem_ready,
        input  gnt, done, rdata, err, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mbs_bus_prio_pick.sv
// Combinational winner selection: saturated DMA, then saturated instruction
// fetch, then fixed priority data > inst > dma.
module mbs_bus_prio_pick
    import mbs_bus_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               sat_inst_i,
    input  logic               sat_dma_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic               valid_o
);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        win_o = '0;
        if (req_i[REQ_DMA] && sat_dma_i) begin
            win_o[REQ_DMA] = 1'b1;
        end else if (req_i[REQ_INST] && sat_inst_i) begin
            win_o[REQ_INST] = 1'b1;
        end else if (req_i[REQ_DATA]) begin
            win_o[REQ_DATA] = 1'b1;
        end else if (req_i[REQ_INST]) begin
            win_o[REQ_INST] = 1'b1;
        end else if (req_i[REQ_DMA]) begin
            win_o[REQ_DMA] = 1'b1;
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/mbs_bus_arbiter.sv
// Three-requester arbiter for the single-ported memory bus: one access in
// flight, starvation override for inst/dma, and a BUSY timeout that reports err.
module mbs_bus_arbiter
    import mbs_bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int TIMEOUT      = TIMEOUT_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic              clk,
    input logic              rst,
    mbs_bus_arbiter_if.slave bus
);

    localparam int TW = cnt_width(TIMEOUT);
    localparam int SW = cnt_width(STARVE_LIMIT);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e              state_q;
    logic [NUM_REQ-1:0]      gnt_q, done_q;
    logic [DATA_WIDTH-1:0]   rdata_q, mem_wdata_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic                    err_q, mem_req_q, mem_we_q;
    logic [TW-1:0]           to_cnt_q;
    logic [SW-1:0]           starve1_q, starve2_q, starve1_d, starve2_d;

    logic [NUM_REQ-1:0]      pick_win;
    logic                    pick_valid;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    sel_we;

    mbs_bus_prio_pick u_pick (
        .req_i      (bus.req),
        .sat_inst_i (starve1_q == STARVE_MAX),
        .sat_dma_i  (starve2_q == STARVE_MAX),
        .win_o      (pick_win),
        .valid_o    (pick_valid)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_win[i]) begin
                sel_addr  = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_we    = bus.we[i];
            end
        end
    end

    // Winner and idle requesters clear; requesting losers count up to the limit.
    always_comb begin
        starve1_d = starve1_q;
        starve2_d = starve2_q;
        if (pick_win[REQ_INST] || !bus.req[REQ_INST]) starve1_d = '0;
        else if (starve1_q != STARVE_MAX)             starve1_d = starve1_q + 1'b1;
        if (pick_win[REQ_DMA] || !bus.req[REQ_DMA])   starve2_d = '0;
        else if (starve2_q != STARVE_MAX)             starve2_d = starve2_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, and the
    // synchronous reset clears every register, abandoning any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            to_cnt_q    <= '0;
            starve1_q   <= '0;
            starve2_q   <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid && !bus.stop) begin
                        state_q     <= ST_BUSY;
                        gnt_q       <= pick_win;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        to_cnt_q    <= '0;
                        starve1_q   <= starve1_d;
                        starve2_q   <= starve2_d;
                    end
                end
                ST_BUSY: begin
                    if (bus.mem_ready || to_cnt_q == TO_LAST) begin
                        state_q     <= ST_RESP;
                        done_q      <= gnt_q;
                        rdata_q     <= bus.mem_ready ? bus.mem_rdata : '0;
                        err_q       <= !bus.mem_ready;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q  <= ST_IDLE;
                    gnt_q    <= '0;
                    rdata_q  <= '0;
                    err_q    <= 1'b0;
                    to_cnt_q <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
